// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory with a shared tristate data bus.
// Every access runs IDLE -> ACCESS -> RESP; RESP doubles as the bus turnaround cycle.
module mem_arbiter #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] wdata0,
  input  logic [DWIDTH-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DWIDTH-1:0] rdata0,
  output logic [DWIDTH-1:0] rdata1,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [AWIDTH-1:0] mem_addr,
  inout  wire  [DWIDTH-1:0] mem_data,
  output logic [1:0]        state_dbg
);

  // Handshake: a requester raises reqN with weN/addrN/wdataN and holds them until
  // ackN, a single-cycle pulse; only the values sampled at the grant edge are used.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [DWIDTH-1:0]   rdata0_q, rdata0_d;
  logic [DWIDTH-1:0]   rdata1_q, rdata1_d;
  logic                grant_any;
  logic                grant_sel;
  logic                drive_bus;

  // On a tie the requester that was not served last wins.
  assign grant_any = req0 | req1;
  assign grant_sel = (req0 && req1) ? ~last_q : req1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    owner_d  = owner_q;
    last_d   = last_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          state_d = S_ACCESS;
          owner_d = grant_sel;
          we_d    = grant_sel ? we1 : we0;
          addr_d  = grant_sel ? addr1 : addr0;
          wdata_d = grant_sel ? wdata1 : wdata0;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        if (!we_q) begin
          if (owner_q) rdata1_d = mem_data;
          else         rdata0_d = mem_data;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        last_d  = owner_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decode from the state register, so asynchronous reset removes them at once.
  always_comb begin
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    drive_bus = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    unique case (state_q)
      S_ACCESS: begin
        mem_wr    = we_q;
        mem_rd    = ~we_q;
        mem_addr  = addr_q;
        drive_bus = we_q;
      end
      S_RESP: begin
        ack0 = ~owner_q;
        ack1 = owner_q;
      end
      default: ;
    endcase
  end

  assign mem_data  = drive_bus ? wdata_q : {DWIDTH{1'bz}};
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random two-port traffic,
// checked against a transaction-level memory/arbitration model.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [4:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic       mem_wr, mem_rd;
  logic [4:0] mem_addr;
  wire  [7:0] mem_data;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  mem_arbiter #(.AWIDTH(5), .DWIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .state_dbg(state_dbg)
  );

  // Memory device on the far side of the bus.
  logic       preload;
  logic [7:0] dev_mem [32];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) dev_mem[i] <= 8'(i * 37 + 5);
    end else if (mem_wr) begin
      dev_mem[mem_addr] <= mem_data;
    end
  end
  assign mem_data = mem_rd ? dev_mem[mem_addr] : 8'bz;

  // Reference model: memory contents, per-port held read data, last served port.
  logic [7:0] ref_mem [32];
  logic [7:0] exp_rdata [2];
  int         model_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [4:0] a, input logic [7:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  function automatic logic ack_of(input int p);
    return (p == 0) ? ack0 : ack1;
  endfunction

  function automatic logic [7:0] rdata_of(input int p);
    return (p == 0) ? rdata0 : rdata1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 5'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 5'd0, 8'd0);
    repeat (2) @(negedge clk);
    check("rst_ack0", {31'd0, ack0}, 0);
    check("rst_ack1", {31'd0, ack1}, 0);
    check("rst_mem_wr", {31'd0, mem_wr}, 0);
    check("rst_mem_rd", {31'd0, mem_rd}, 0);
    check("rst_mem_addr", {27'd0, mem_addr}, 0);
    check("rst_rdata", {16'd0, rdata0, rdata1}, 0);
    rst = 1'b0;
    exp_rdata[0] = 8'd0;
    exp_rdata[1] = 8'd0;
    model_last = 1;
    @(negedge clk);
  endtask

  // One isolated transaction; called and returns at a negedge in IDLE.
  task automatic xact(input int p, input logic w, input logic [4:0] a,
                      input logic [7:0] d, input bit drop_early);
    drive(p, 1'b1, w, a, d);
    @(negedge clk);
    if (drop_early) drive(p, 1'b0, w, a, d);
    check("acc_mem_wr", {31'd0, mem_wr}, {31'd0, w});
    check("acc_mem_rd", {31'd0, mem_rd}, {31'd0, !w});
    check("acc_mem_addr", {27'd0, mem_addr}, {27'd0, a});
    check("acc_mem_data", {24'd0, mem_data}, w ? {24'd0, d} : {24'd0, ref_mem[a]});
    check("acc_no_ack", {30'd0, ack1, ack0}, 0);
    @(negedge clk);
    if (!w) exp_rdata[p] = ref_mem[a];
    else    ref_mem[a] = d;
    model_last = p;
    check("resp_ack", {30'd0, ack1, ack0}, (p == 0) ? 32'd1 : 32'd2);
    check("resp_strobes", {30'd0, mem_wr, mem_rd}, 0);
    check("resp_rdata0", {24'd0, rdata0}, {24'd0, exp_rdata[0]});
    check("resp_rdata1", {24'd0, rdata1}, {24'd0, exp_rdata[1]});
    drive(p, 1'b0, w, a, d);
    @(negedge clk);
    check("idle_ack", {30'd0, ack1, ack0}, 0);
  endtask

  // random-phase bookkeeping
  logic       pend [2];
  logic       p_we [2];
  logic [4:0] p_addr [2];
  logic [7:0] p_data [2];
  int         p_start [2];
  int         prev_ack_port, prev_ack_cycle;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    preload = 1'b1;
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i * 37 + 5);
    do_reset();
    preload = 1'b0;

    // single write then read-back on port 0
    xact(0, 1'b1, 5'd5, 8'hA5, 1'b0);
    xact(0, 1'b0, 5'd5, 8'h00, 1'b0);
    check("wr_rd_rdata0", {24'd0, rdata0}, 32'hA5);

    // cross-port: port 1 writes, port 0 reads it back
    xact(1, 1'b1, 5'd31, 8'h3C, 1'b0);
    xact(1, 1'b0, 5'd4, 8'h00, 1'b0);
    xact(0, 1'b0, 5'd31, 8'h00, 1'b0);
    check("cross_rdata0", {24'd0, rdata0}, 32'h3C);

    // early drop of req1 after grant
    xact(1, 1'b0, 5'd9, 8'h00, 1'b1);

    // reset in the middle of a write to addr 2
    xact(0, 1'b1, 5'd2, 8'h11, 1'b0);
    drive(0, 1'b1, 1'b1, 5'd2, 8'hFF);
    @(negedge clk);
    check("mid_pre_wr", {31'd0, mem_wr}, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_wr_drop", {31'd0, mem_wr}, 0);
    check("mid_rd_low", {31'd0, mem_rd}, 0);
    check("mid_addr", {27'd0, mem_addr}, 0);
    check("mid_rdata", {16'd0, rdata0, rdata1}, 0);
    check("mid_ack", {30'd0, ack1, ack0}, 0);
    exp_rdata[0] = 8'd0;
    exp_rdata[1] = 8'd0;
    model_last = 1;
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 5'd0, 8'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mid_no_ack", {30'd0, ack1, ack0}, 0);
    end
    xact(0, 1'b0, 5'd2, 8'h00, 1'b0);
    check("mid_prior", {24'd0, rdata0}, 32'h11);

    // tie after reset: both hold reads, acks alternate from port 0
    do_reset();
    drive(0, 1'b1, 1'b0, 5'd3, 8'd0);
    drive(1, 1'b1, 1'b0, 5'd7, 8'd0);
    for (int k = 0; k < 4; k++) begin
      int win;
      win = (model_last == 0) ? 1 : 0;
      repeat ((k == 0) ? 1 : 2) begin
        @(negedge clk);
        check("tie_gap", {30'd0, ack1, ack0}, 0);
      end
      @(negedge clk);
      exp_rdata[win] = ref_mem[(win == 0) ? 3 : 7];
      model_last = win;
      check("tie_ack", {30'd0, ack1, ack0}, (win == 0) ? 32'd1 : 32'd2);
      check("tie_rdata", {24'd0, rdata_of(win)}, {24'd0, exp_rdata[win]});
    end
    drive(0, 1'b0, 1'b0, 5'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 5'd0, 8'd0);
    @(negedge clk);

    // random two-port traffic
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    prev_ack_port = model_last;
    prev_ack_cycle = -100;
    for (int c = 0; c < 700; c++) begin
      bit quiet;
      quiet = (c >= 600);
      if (mem_rd && mem_wr) check("bus_excl", 1, 0);
      if (mem_rd) check("bus_rd_data", {24'd0, mem_data}, {24'd0, ref_mem[mem_addr]});
      if (ack0 && ack1) check("ack_excl", 1, 0);
      for (int p = 0; p < 2; p++) begin
        if (ack_of(p)) begin
          int q;
          q = 1 - p;
          check("rnd_pending", {31'd0, pend[p]}, 1);
          check("rnd_latency", (c - p_start[p] <= 8) ? 32'd1 : 32'd0, 1);
          check("rnd_rr", (prev_ack_port == p && pend[q] && p_start[q] <= prev_ack_cycle + 1)
                          ? 32'd1 : 32'd0, 0);
          if (p_we[p]) ref_mem[p_addr[p]] = p_data[p];
          else         exp_rdata[p] = ref_mem[p_addr[p]];
          check("rnd_rdata0", {24'd0, rdata0}, {24'd0, exp_rdata[0]});
          check("rnd_rdata1", {24'd0, rdata1}, {24'd0, exp_rdata[1]});
          pend[p] = 1'b0;
          prev_ack_port = p;
          prev_ack_cycle = c;
          drive(p, 1'b0, 1'b0, 5'd0, 8'd0);
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (!quiet && !pend[p] && $urandom_range(0, 2) != 0) begin
          pend[p]    = 1'b1;
          p_we[p]    = 1'($urandom_range(0, 1));
          p_addr[p]  = 5'($urandom_range(0, 31));
          p_data[p]  = 8'($urandom);
          p_start[p] = c;
          drive(p, 1'b1, p_we[p], p_addr[p], p_data[p]);
        end
      end
      @(negedge clk);
    end
    check("rnd_drained", {30'd0, pend[1], pend[0]}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AWIDTH, default 5, meaning memory address width in bits.
REQ-002 The block SHALL have parameter DWIDTH, default 8, meaning memory data width in bits.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port req0 / req1  input  1  access request from requester 0 / 1.
REQ-006 The block SHALL have port we0 / we1  input  1  1 means write, 0 means read, for requester 0 / 1.
REQ-007 The block SHALL have port addr0 / addr1  input  AWIDTH  access address for requester 0 / 1.
REQ-008 The block SHALL have port wdata0 / wdata1  input  DWIDTH  write data for requester 0 / 1.
REQ-009 The block SHALL have port ack0 / ack1  output  1  one-cycle completion pulse for requester 0 / 1.
REQ-010 The block SHALL have port rdata0 / rdata1  output  DWIDTH  read data for requester 0 / 1, valid with ack and held afterwards.
REQ-011 The block SHALL have port mem_wr  output  1  memory write strobe.
REQ-012 The block SHALL have port mem_rd  output  1  memory read enable.
REQ-013 The block SHALL have port mem_addr  output  AWIDTH  memory address.
REQ-014 The block SHALL have port mem_data  inout  DWIDTH  shared bidirectional memory data bus.

Function
REQ-015 The block SHALL implement a state machine with states IDLE, ACCESS and RESP.
REQ-016 In IDLE, when req0 or req1 is sampled high, the block SHALL latch the winner's we, addr and wdata, record the winner, and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: when only one req is high, that requester wins; when both are high, the requester not served most recently wins.
REQ-018 In ACCESS, mem_addr SHALL equal the latched address, and mem_wr SHALL equal the latched we while mem_rd equals its inverse.
REQ-019 On a write in ACCESS, mem_data SHALL be driven with the latched wdata; in every other state and on reads, mem_data SHALL be high-impedance.
REQ-020 On a read, the block SHALL capture mem_data into the winner's rdata register at the rising edge that ends ACCESS.
REQ-021 ACCESS SHALL always last exactly one cycle and then go to RESP.
REQ-022 In RESP, the block SHALL assert the winner's ack for exactly one cycle, update the last-served pointer, and return to IDLE.
REQ-023 Latency SHALL be fixed: with req sampled at edge N, mem access occurs in cycle N..N+1 and ack is high in cycle N+1..N+2; one access completes every 3 cycles at most.
REQ-024 mem_rd and mem_wr SHALL never be high simultaneously, and SHALL both be low in IDLE and RESP, so that RESP provides one cycle of bus turnaround.
REQ-025 Requesters SHALL hold req, we, addr and wdata stable until ack; the block SHALL use only the values latched in IDLE.
REQ-026 A req deasserted after grant SHALL NOT abort the access; the access SHALL complete and ack SHALL still pulse.
REQ-027 A requester holding req high after its ack SHALL be treated as a new request in the following IDLE cycle.
REQ-028 rdata0 and rdata1 SHALL change only on a read completed for that port; writes SHALL leave them unchanged.
REQ-029 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-030 While rst is high, the block SHALL force, asynchronously: state to IDLE, ack0/ack1, mem_wr and mem_rd to 0, mem_addr to 0, mem_data to high-impedance, rdata0/rdata1 to 0, and the last-served pointer so that requester 0 wins the first tie.
REQ-031 Reset asserted during ACCESS SHALL drop mem_wr immediately, so no memory write occurs at the next edge, and SHALL produce no ack.

Verification
REQ-032 Single write/read: req0=1, we0=1, addr0=5, wdata0=0xA5 -> mem_wr high for one cycle with mem_addr=5 and mem_data=0xA5, ack0 two cycles after sampling; then a read of addr0=5 -> rdata0=0xA5 with ack0.
REQ-033 Tie, round-robin: req0 and req1 both held high with reads at 3 and 7 -> acks alternate ack0, ack1, ack0, ack1, 3 cycles apart, with ack0 first after reset.
REQ-034 Cross-port data: req1 writes 0x3C to addr 31, then req0 reads addr 31 -> rdata0=0x3C, and rdata1 is unchanged.
REQ-035 Bus discipline: on mixed back-to-back read/write traffic -> mem_rd and mem_wr are never both 1, and mem_data is never driven by the block while mem_rd=1.
REQ-036 Reset mid-access: rst asserted during an ACCESS cycle of a write of 0xFF to addr 2 -> no ack, outputs at reset values immediately, and a later read of addr 2 returns the prior contents.
REQ-037 Early drop: req1 deasserted the cycle after grant -> the access completes and ack1 pulses once.
